// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//
// Memory-side responder for the multicycle core's single shared memory port.
// Each request is serviced as one word access to an internal RAM after a
// fixed number of wait states. Completion is signalled with a one-cycle
// ready pulse. Misaligned, out-of-range and read+write requests are faulted.
//
// Ports:
//   clk           single clock, rising edge
//   reset         synchronous, active-high
//   memory_read   read request strobe
//   memory_write  write request strobe
//   address       byte address (ADDR_WIDTH)
//   write_data    store data (DATA_WIDTH)
//   write_strobe  byte-lane enables, bit i selects bits [8i+7:8i]
//   read_data     registered load data
//   ready         one-cycle completion pulse
//   busy          high while a request is in flight
//   access_error  high in the ready cycle of a faulted request
// ---------------------------------------------------------------------------
module data_memory_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  memory_read,
   input  logic                  memory_write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic [3:0]            write_strobe,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  ready,
   output logic                  busy,
   output logic                  access_error
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] COUNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESPOND
   } state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   state_t                state_q, state_d;
   logic [3:0]            count_q, count_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            strobe_q, strobe_d;
   logic                  is_write_q, is_write_d;
   logic                  fault_q, fault_d;
   logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
   logic                  error_q, error_d;

   logic                  req;
   logic [IDX_W-1:0]      req_idx;
   logic                  req_fault;
   logic                  enter_respond;
   logic [IDX_W-1:0]      resp_idx;
   logic                  resp_fault;
   logic                  resp_is_write;
   logic                  mem_we;

   // Decode the live request. Any address bit above the word-index range
   // makes the access out of range; a combined read+write is also a fault.
   always_comb begin
      req       = memory_read | memory_write;
      req_idx   = address[IDX_W+1:2];
      req_fault = (address[1:0] != 2'b00)
                | ((address >> (IDX_W + 2)) != '0)
                | (memory_read & memory_write);
   end

   // Next-state and datapath. With zero wait states the response is loaded
   // on the acceptance edge itself, so the live inputs feed the response
   // logic instead of the capture registers, which are not yet loaded.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      idx_d         = idx_q;
      wdata_d       = wdata_q;
      strobe_d      = strobe_q;
      is_write_d    = is_write_q;
      fault_d       = fault_q;
      read_data_d   = read_data_q;
      error_d       = 1'b0;
      enter_respond = 1'b0;
      resp_idx      = idx_q;
      resp_fault    = fault_q;
      resp_is_write = is_write_q;
      mem_we        = 1'b0;

      case (state_q)
         IDLE: begin
            if (req) begin
               idx_d      = req_idx;
               wdata_d    = write_data;
               strobe_d   = write_strobe;
               is_write_d = memory_write;
               fault_d    = req_fault;
               if (WAIT_CYCLES == 0) begin
                  state_d       = RESPOND;
                  enter_respond = 1'b1;
                  resp_idx      = req_idx;
                  resp_fault    = req_fault;
                  resp_is_write = memory_write;
               end else begin
                  state_d = WAIT;
                  count_d = COUNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (count_q == 4'd0) begin
               state_d       = RESPOND;
               enter_respond = 1'b1;
            end else begin
               count_d = count_q - 4'd1;
            end
         end
         RESPOND: begin
            state_d = IDLE;
            mem_we  = is_write_q & ~fault_q;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Reads and faults update read_data; good writes leave it alone.
      if (enter_respond) begin
         error_d = resp_fault;
         if (resp_fault) begin
            read_data_d = '0;
         end else if (!resp_is_write) begin
            read_data_d = mem[resp_idx];
         end
      end
   end

   // Control and capture registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= 4'd0;
         idx_q       <= '0;
         wdata_q     <= '0;
         strobe_q    <= 4'd0;
         is_write_q  <= 1'b0;
         fault_q     <= 1'b0;
         read_data_q <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         strobe_q    <= strobe_d;
         is_write_q  <= is_write_d;
         fault_q     <= fault_d;
         read_data_q <= read_data_d;
         error_q     <= error_d;
      end
   end

   // RAM write port. Contents survive reset, but a reset in the RESPOND
   // cycle must still cancel the pending store.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (strobe_q[lane]) begin
               mem[idx_q][8*lane +: 8] <= wdata_q[8*lane +: 8];
            end
         end
      end
   end

   always_comb begin
      read_data    = read_data_q;
      ready        = (state_q == RESPOND);
      busy         = (state_q != IDLE);
      access_error = error_q;
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_data_memory_responder
//
// Self-checking bench for data_memory_responder. Two instances run side by
// side: dut0 with two wait states and dut1 with none. A transaction-level
// model (request in flight, cycles remaining, word array) predicts every
// output on every cycle; directed sequences also check hand-computed values.
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

   localparam int WAIT0 = 2;
   localparam int WAIT1 = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_rd    [2];
   logic        mem_wr    [2];
   logic [31:0] mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [3:0]  mem_strb  [2];
   logic [31:0] rdata     [2];
   logic        rdy       [2];
   logic        bsy       [2];
   logic        err       [2];

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   data_memory_responder #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT0)
   ) dut0 (
      .clk(clk), .reset(reset),
      .memory_read(mem_rd[0]), .memory_write(mem_wr[0]),
      .address(mem_addr[0]), .write_data(mem_wdata[0]), .write_strobe(mem_strb[0]),
      .read_data(rdata[0]), .ready(rdy[0]), .busy(bsy[0]), .access_error(err[0])
   );

   data_memory_responder #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT1)
   ) dut1 (
      .clk(clk), .reset(reset),
      .memory_read(mem_rd[1]), .memory_write(mem_wr[1]),
      .address(mem_addr[1]), .write_data(mem_wdata[1]), .write_strobe(mem_strb[1]),
      .read_data(rdata[1]), .ready(rdy[1]), .busy(bsy[1]), .access_error(err[1])
   );

   // Behavioural model: one outstanding request per instance, counted in
   // cycles until its response, plus a word array with validity flags.
   logic [31:0] m_mem    [2][1024];
   bit          m_known  [2][1024];
   bit          m_active [2];
   int          m_left   [2];
   bit          m_fault  [2];
   bit          m_isw    [2];
   int          m_idx    [2];
   logic [31:0] m_wd     [2];
   logic [3:0]  m_st     [2];
   logic [31:0] m_rd     [2];
   bit          m_rdk    [2];
   int          wait_of  [2] = '{WAIT0, WAIT1};

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_active[i] = 1'b0;
         m_rdk[i]    = 1'b0;
         for (int w = 0; w < 1024; w++) m_known[i][w] = 1'b0;
      end
   end

   // Response becomes visible: loads return the stored word, faults zero.
   task automatic modelRespond(input int i);
      if (m_fault[i]) begin
         m_rd[i]  = 32'h0;
         m_rdk[i] = 1'b1;
      end else if (!m_isw[i]) begin
         m_rd[i]  = m_mem[i][m_idx[i]];
         m_rdk[i] = m_known[i][m_idx[i]];
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_active[i] = 1'b0;
            m_left[i]   = 0;
            m_rd[i]     = 32'h0;
            m_rdk[i]    = 1'b1;
         end else if (m_active[i]) begin
            if (m_left[i] == 0) begin
               if (m_isw[i] && !m_fault[i]) begin
                  logic [31:0] word;
                  word = m_mem[i][m_idx[i]];
                  for (int b = 0; b < 4; b++)
                     if (m_st[i][b]) word[8*b +: 8] = m_wd[i][8*b +: 8];
                  m_mem[i][m_idx[i]] = word;
                  if (m_st[i] == 4'hF) m_known[i][m_idx[i]] = 1'b1;
               end
               m_active[i] = 1'b0;
            end else begin
               m_left[i]--;
               if (m_left[i] == 0) modelRespond(i);
            end
         end else if (mem_rd[i] || mem_wr[i]) begin
            m_idx[i]    = int'(mem_addr[i][11:2]);
            m_fault[i]  = (mem_addr[i][1:0] != 2'b00) || (mem_addr[i][31:12] != 20'h0)
                       || (mem_rd[i] && mem_wr[i]);
            m_isw[i]    = mem_wr[i];
            m_wd[i]     = mem_wdata[i];
            m_st[i]     = mem_strb[i];
            m_active[i] = 1'b1;
            m_left[i]   = wait_of[i];
            if (m_left[i] == 0) modelRespond(i);
         end
      end
   end

   // Compare process: every cycle, every output of both instances.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 2; i++) begin
            bit exp_ready;
            exp_ready = m_active[i] && (m_left[i] == 0);
            checks++;
            if (rdy[i] !== exp_ready) begin
               errors++;
               $display("[TB] FAIL model ready dut%0d @%0t: got %b expected %b", i, $time, rdy[i], exp_ready);
            end
            checks++;
            if (bsy[i] !== m_active[i]) begin
               errors++;
               $display("[TB] FAIL model busy dut%0d @%0t: got %b expected %b", i, $time, bsy[i], m_active[i]);
            end
            checks++;
            if (err[i] !== (exp_ready && m_fault[i])) begin
               errors++;
               $display("[TB] FAIL model access_error dut%0d @%0t: got %b expected %b", i, $time, err[i],
                        exp_ready && m_fault[i]);
            end
            if (m_rdk[i]) begin
               checks++;
               if (rdata[i] !== m_rd[i]) begin
                  errors++;
                  $display("[TB] FAIL model read_data dut%0d @%0t: got %h expected %h", i, $time, rdata[i], m_rd[i]);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // One request on instance i: strobes high for a single cycle, then wait
   // (bounded) for ready. Returns at the ready cycle with outputs sampled.
   task automatic applyStimulus(input int i, input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] strb,
                                output logic [31:0] got_rd, output logic got_err);
      int lat;
      @(negedge clk);
      mem_rd[i]    = rd;
      mem_wr[i]    = wr;
      mem_addr[i]  = addr;
      mem_wdata[i] = data;
      mem_strb[i]  = strb;
      @(negedge clk);
      mem_rd[i] = 1'b0;
      mem_wr[i] = 1'b0;
      lat = 1;
      while (!rdy[i] && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput($sformatf("latency dut%0d addr %h", i, addr), 32'(lat), 32'(wait_of[i] + 1));
      got_rd  = rdata[i];
      got_err = err[i];
   endtask

   initial begin
      #300000;
      errors++;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      logic [31:0] got_rd;
      logic        got_err;
      int          pulses;
      int          doubles;
      bit          prev;

      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         mem_rd[i] = 1'b0; mem_wr[i] = 1'b0; mem_addr[i] = '0; mem_wdata[i] = '0; mem_strb[i] = '0;
      end
      repeat (3) @(posedge clk);
      cmp_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("reset ready dut%0d", i), 32'(rdy[i]), 32'h0);
         checkOutput($sformatf("reset busy dut%0d", i), 32'(bsy[i]), 32'h0);
         checkOutput($sformatf("reset error dut%0d", i), 32'(err[i]), 32'h0);
         checkOutput($sformatf("reset read_data dut%0d", i), rdata[i], 32'h0);
      end
      reset = 1'b0;

      // Word write then read.
      applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, got_rd, got_err);
      checkOutput("write 0x10 error", 32'(got_err), 32'h0);
      applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("read 0x10 data", got_rd, 32'hDEADBEEF);
      checkOutput("read 0x10 error", 32'(got_err), 32'h0);

      // Byte lanes 0 and 2 only.
      applyStimulus(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'hF, got_rd, got_err);
      applyStimulus(0, 0, 1, 32'h20, 32'h11223344, 4'b0101, got_rd, got_err);
      applyStimulus(0, 1, 0, 32'h20, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("byte lane read", got_rd, 32'hAA22CC44);
      checkOutput("byte lane model", m_rd[0], 32'hAA22CC44);

      // Misaligned read and write.
      applyStimulus(0, 1, 0, 32'h13, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("misaligned read error", 32'(got_err), 32'h1);
      checkOutput("misaligned read data", got_rd, 32'h0);
      applyStimulus(0, 0, 1, 32'h22, 32'hFFFFFFFF, 4'hF, got_rd, got_err);
      checkOutput("misaligned write error", 32'(got_err), 32'h1);
      applyStimulus(0, 1, 0, 32'h20, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("mem[8] after misaligned write", got_rd, 32'hAA22CC44);

      // Out of range.
      applyStimulus(0, 1, 0, 32'h1000, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("out of range error", 32'(got_err), 32'h1);
      checkOutput("out of range data", got_rd, 32'h0);

      // Simultaneous strobes.
      applyStimulus(0, 1, 1, 32'h10, 32'h0, 4'hF, got_rd, got_err);
      checkOutput("read+write error", 32'(got_err), 32'h1);
      applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("read after read+write", got_rd, 32'hDEADBEEF);

      // Zero strobe write completes without changing RAM or read_data.
      applyStimulus(0, 0, 1, 32'h10, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("zero strobe error", 32'(got_err), 32'h0);
      checkOutput("read_data held over write", got_rd, 32'hDEADBEEF);
      applyStimulus(0, 1, 0, 32'h10, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("read after zero strobe", got_rd, 32'hDEADBEEF);

      // Reset during WAIT of a write.
      applyStimulus(0, 0, 1, 32'h30, 32'h12345678, 4'hF, got_rd, got_err);
      @(negedge clk);
      mem_wr[0] = 1'b1; mem_addr[0] = 32'h30; mem_wdata[0] = 32'h5; mem_strb[0] = 4'hF;
      @(negedge clk);
      mem_wr[0] = 1'b0;
      checkOutput("busy before mid-wait reset", 32'(bsy[0]), 32'h1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid-wait reset busy", 32'(bsy[0]), 32'h0);
      checkOutput("mid-wait reset ready", 32'(rdy[0]), 32'h0);
      checkOutput("mid-wait reset read_data", rdata[0], 32'h0);
      reset = 1'b0;
      applyStimulus(0, 1, 0, 32'h30, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("word after mid-wait reset", got_rd, 32'h12345678);

      // Reset during RESPOND of a write.
      applyStimulus(0, 0, 1, 32'h30, 32'h5, 4'hF, got_rd, got_err);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(0, 1, 0, 32'h30, 32'h0, 4'h0, got_rd, got_err);
      checkOutput("word after respond reset", got_rd, 32'h12345678);

      // Zero wait states, strobes held high continuously.
      @(negedge clk);
      mem_wr[1] = 1'b1; mem_addr[1] = 32'h40; mem_wdata[1] = 32'hCAFEF00D; mem_strb[1] = 4'hF;
      pulses = 0; doubles = 0; prev = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (rdy[1]) pulses++;
         if (rdy[1] && prev) doubles++;
         prev = rdy[1];
      end
      checkOutput("back-to-back pulses", 32'(pulses), 32'd10);
      checkOutput("back-to-back double pulses", 32'(doubles), 32'd0);
      mem_wr[1] = 1'b0; mem_rd[1] = 1'b1;
      @(negedge clk);
      checkOutput("held read ready", 32'(rdy[1]), 32'h1);
      checkOutput("held read data", rdata[1], 32'hCAFEF00D);
      repeat (5) @(negedge clk);
      mem_rd[1] = 1'b0;

      // Randomised traffic on both instances, checked by the model.
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            int sel;
            int kind;
            int word;
            sel  = int'($urandom_range(0, 9));
            kind = int'($urandom_range(0, 9));
            word = int'($urandom_range(0, 15));
            mem_rd[i] = (sel <= 3) || (sel == 7);
            mem_wr[i] = (sel >= 4 && sel <= 7);
            if (kind < 8)       mem_addr[i] = 32'(word * 4);
            else if (kind == 8) mem_addr[i] = 32'(word * 4) + 32'($urandom_range(1, 3));
            else                mem_addr[i] = 32'h1000 + 32'(word * 4);
            mem_wdata[i] = $urandom;
            mem_strb[i]  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
         end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         mem_rd[i] = 1'b0;
         mem_wr[i] = 1'b0;
      end
      repeat (6) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
